// File: rtl/e_md_hilo_unit.sv
// rtl/e_md_hilo_unit.sv - E-stage multiply/divide unit with HI/LO pair and GRF write-data select
module e_md_hilo_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E_md_start,
    input  logic [2:0]       E_md_op,
    input  logic [WIDTH-1:0] E_A,
    input  logic [WIDTH-1:0] E_B,
    input  logic [WIDTH-1:0] E_ans,
    input  logic [WIDTH-1:0] E_pc,
    input  logic [1:0]       s_E_GRF_Wdata,
    output logic             E_busy,
    output logic             E_md_stall,
    output logic [WIDTH-1:0] E_HI,
    output logic [WIDTH-1:0] E_LO,
    output logic [WIDTH-1:0] E_GRF_Wdata
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    state_t           state;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   abs_a, abs_b, div_b, q_u, r_u, q_s, r_s, uq, ur;
    logic               a_neg, b_neg, b_zero;

    assign state = (cnt_q == '0) ? IDLE : RUN;

    // Low 2*WIDTH bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{WIDTH{E_A[WIDTH-1]}}, E_A} * {{WIDTH{E_B[WIDTH-1]}}, E_B};
    assign prod_u = {{WIDTH{1'b0}}, E_A} * {{WIDTH{1'b0}}, E_B};

    assign a_neg  = E_A[WIDTH-1];
    assign b_neg  = E_B[WIDTH-1];
    assign b_zero = (E_B == '0);
    assign abs_a  = a_neg ? -E_A : E_A;
    assign abs_b  = b_neg ? -E_B : E_B;
    assign div_b  = b_zero ? WIDTH'(1) : abs_b;
    // Signed divide via magnitudes; min_int / -1 naturally wraps to min_int, remainder 0.
    assign q_u    = abs_a / div_b;
    assign r_u    = abs_a % div_b;
    assign q_s    = (a_neg ^ b_neg) ? -q_u : q_u;
    assign r_s    = a_neg ? -r_u : r_u;
    assign uq     = E_A / (b_zero ? WIDTH'(1) : E_B);
    assign ur     = E_A % (b_zero ? WIDTH'(1) : E_B);

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        cnt_d     = cnt_q;
        case (state)
            IDLE: begin
                if (E_md_start) begin
                    case (E_md_op)
                        3'b000: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_wr_d = 1'b1;
                            cnt_d     = MUL_CNT;
                        end
                        3'b001: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = MUL_CNT;
                        end
                        3'b010: begin
                            pend_hi_d = r_s;
                            pend_lo_d = q_s;
                            pend_wr_d = !b_zero;
                            cnt_d     = DIV_CNT;
                        end
                        3'b011: begin
                            pend_hi_d = ur;
                            pend_lo_d = uq;
                            pend_wr_d = !b_zero;
                            cnt_d     = DIV_CNT;
                        end
                        3'b100:  hi_d = E_A;
                        3'b101:  lo_d = E_A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE && pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign E_busy     = (cnt_q != '0);
    assign E_md_stall = E_busy | (E_md_start & ~E_md_op[2]);
    assign E_HI       = hi_q;
    assign E_LO       = lo_q;

    always_comb begin
        case (s_E_GRF_Wdata)
            2'b00:   E_GRF_Wdata = E_ans;
            2'b01:   E_GRF_Wdata = E_pc + WIDTH'(8);
            2'b10:   E_GRF_Wdata = hi_q;
            default: E_GRF_Wdata = lo_q;
        endcase
    end
endmodule

// File: tb/tb_e_md_hilo_unit.sv
// tb/tb_e_md_hilo_unit.sv - self-checking bench for e_md_hilo_unit
module tb_e_md_hilo_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        E_md_start;
    logic [2:0]  E_md_op;
    logic [31:0] E_A, E_B, E_ans, E_pc;
    logic [1:0]  s_E_GRF_Wdata;
    logic        E_busy, E_md_stall;
    logic [31:0] E_HI, E_LO, E_GRF_Wdata;

    int n_pass = 0;
    int n_total = 0;

    e_md_hilo_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .E_md_start(E_md_start), .E_md_op(E_md_op),
        .E_A(E_A), .E_B(E_B), .E_ans(E_ans), .E_pc(E_pc),
        .s_E_GRF_Wdata(s_E_GRF_Wdata), .E_busy(E_busy), .E_md_stall(E_md_stall),
        .E_HI(E_HI), .E_LO(E_LO), .E_GRF_Wdata(E_GRF_Wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    logic [31:0] m_hi, m_lo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (E_busy && cycles < 200) begin
            cycles++;
            tick();
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int   cyc;
        exp_t e;
        E_md_start = 1'b1; E_md_op = v.op; E_A = v.a; E_B = v.b;
        #1;
        check($sformatf("v%0d_stall_start", idx), {31'b0, E_md_stall}, 32'd1);
        sb.push_back('{hi: v.hi, lo: v.lo, lat: v.lat});
        tick();
        E_md_start = 1'b0;
        E_A = $urandom; E_B = $urandom;
        check($sformatf("v%0d_busy", idx), {31'b0, E_busy}, 32'd1);
        check($sformatf("v%0d_hi_during", idx), E_HI, m_hi);
        wait_idle(cyc);
        e = sb.pop_front();
        check($sformatf("v%0d_lat", idx), cyc, e.lat);
        check($sformatf("v%0d_hi", idx), E_HI, e.hi);
        check($sformatf("v%0d_lo", idx), E_LO, e.lo);
        m_hi = e.hi; m_lo = e.lo;
    endtask

    initial begin
        int cyc;
        vecs[0] = '{3'b000, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{3'b001, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{3'b010, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{3'b011, 32'h7,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{3'b011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vecs[6] = '{3'b010, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

        reset = 1'b0; E_md_start = 1'b0; E_md_op = 3'b000;
        E_A = '0; E_B = '0; E_ans = '0; E_pc = '0; s_E_GRF_Wdata = 2'b00;
        m_hi = '0; m_lo = '0;
        #12;
        check("rst_hi", E_HI, 32'h0);
        check("rst_lo", E_LO, 32'h0);
        check("rst_busy", {31'b0, E_busy}, 32'd0);
        E_md_start = 1'b1; E_md_op = 3'b100; #1;
        check("stall_mthi_idle", {31'b0, E_md_stall}, 32'd0);
        E_md_op = 3'b010; #1;
        check("stall_div_idle", {31'b0, E_md_stall}, 32'd1);
        E_md_start = 1'b0; #1;
        check("stall_none", {31'b0, E_md_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Back-to-back: each op starts in the cycle right after busy falls.
        for (int i = 0; i < 8; i++) run_op(vecs[i], i);

        // mthi issued while busy must be dropped.
        E_md_start = 1'b1; E_md_op = 3'b011; E_A = 32'd7; E_B = 32'd2;
        tick();
        E_md_op = 3'b100; E_A = 32'h12345678;
        #1;
        check("stall_busy_mthi", {31'b0, E_md_stall}, 32'd1);
        tick();
        E_md_start = 1'b0;
        wait_idle(cyc);
        check("busy_mthi_lat", cyc, 32'd9);
        check("mthi_ignored_hi", E_HI, 32'h1);
        check("divu72_lo", E_LO, 32'h3);

        E_md_start = 1'b1; E_md_op = 3'b100; E_A = 32'h12345678;
        tick();
        E_md_start = 1'b0;
        check("mthi_hi", E_HI, 32'h12345678);
        check("mthi_nobusy", {31'b0, E_busy}, 32'd0);
        s_E_GRF_Wdata = 2'b10; #1;
        check("mux_hi", E_GRF_Wdata, 32'h12345678);
        E_md_start = 1'b1; E_md_op = 3'b101; E_A = 32'hCAFEF00D;
        tick();
        E_md_start = 1'b0;
        check("mtlo_lo", E_LO, 32'hCAFEF00D);
        s_E_GRF_Wdata = 2'b11; #1;
        check("mux_lo", E_GRF_Wdata, 32'hCAFEF00D);

        // Undefined opcode leaves state alone.
        E_md_start = 1'b1; E_md_op = 3'b111; E_A = 32'h55555555;
        #1;
        check("stall_undef", {31'b0, E_md_stall}, 32'd0);
        tick();
        E_md_start = 1'b0;
        check("undef_hi", E_HI, 32'h12345678);
        check("undef_lo", E_LO, 32'hCAFEF00D);
        check("undef_busy", {31'b0, E_busy}, 32'd0);

        // Reset in the middle of a div aborts it.
        E_md_start = 1'b1; E_md_op = 3'b010; E_A = 32'd100; E_B = 32'd3;
        tick();
        E_md_start = 1'b0;
        tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_hi", E_HI, 32'h0);
        check("midrst_lo", E_LO, 32'h0);
        check("midrst_busy", {31'b0, E_busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("postrst_hi", E_HI, 32'h0);
        check("postrst_lo", E_LO, 32'h0);
        check("postrst_busy", {31'b0, E_busy}, 32'd0);

        // Write-data mux.
        E_ans = 32'hA5A5A5A5; E_pc = 32'h00003000;
        s_E_GRF_Wdata = 2'b00; #1;
        check("mux_ans", E_GRF_Wdata, 32'hA5A5A5A5);
        s_E_GRF_Wdata = 2'b01; #1;
        check("mux_pc8", E_GRF_Wdata, 32'h00003008);
        E_pc = 32'hFFFFFFFC; #1;
        check("mux_pc8_wrap", E_GRF_Wdata, 32'h00000004);

        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/e_md_hilo_unit.md
# e_md_hilo_unit

Execute-stage multiply/divide unit with the HI/LO register pair and the E-stage GRF write-data selector. Multi-cycle mult/div operations run with parametrised latency; the unit drives a busy/stall indication to the hazard unit. It owns HI/LO state and selects among ALU result, PC+8, HI and LO for the E-stage write-back value. It sits between the ALU and the E/M pipeline register.

## Interface
- WIDTH, 32, datapath width (HI, LO, operands, write data)
- MUL_LAT, 5, cycles from accepted mult/multu to HI/LO update (≥1)
- DIV_LAT, 10, cycles from accepted div/divu to HI/LO update (≥1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- E_md_start  in  1  E-stage instruction is a valid mult/div/mthi/mtlo this cycle
- E_md_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; others no-op
- E_A, E_B  in  WIDTH  rs/rt operands after forwarding
- E_ans  in  WIDTH  ALU result
- E_pc  in  WIDTH  PC of E-stage instruction
- s_E_GRF_Wdata  in  2  00 E_ans, 01 E_pc+8, 10 HI, 11 LO
- E_busy  out  1  registered; high while a mult/div is in flight
- E_md_stall  out  1  combinational; E_busy OR (E_md_start AND op is mult/multu/div/divu)
- E_HI, E_LO  out  WIDTH  current HI/LO register values
- E_GRF_Wdata  out  WIDTH  selected write data

## Operation
- States: IDLE (cnt==0), RUN (cnt>0). E_busy = (cnt!=0), registered.
- IDLE + E_md_start + mult/multu/div/divu: compute result from E_A/E_B, latch into pend_hi/pend_lo, load cnt with MUL_LAT or DIV_LAT → RUN.
- RUN: cnt decrements each edge; on the edge where cnt goes 1→0, HI←pend_hi, LO←pend_lo → IDLE.
- mult: signed 2·WIDTH product; HI = upper WIDTH bits, LO = lower. multu: unsigned.
- div: LO = quotient truncated toward zero, HI = remainder with the dividend's sign. divu: unsigned.
- Divide by zero (E_B==0): operation is accepted, busy for DIV_LAT, HI/LO unchanged at commit.
- Signed overflow (min_int / −1): LO = min_int, HI = 0.
- mthi/mtlo in IDLE: HI (or LO) ← E_A at the next edge, no busy.
- Any E_md_start while E_busy is ignored. The hazard unit guarantees stall via E_md_stall, so the instruction retries after busy drops.
- Undefined op codes are no-ops.
- E_GRF_Wdata mux: 00 E_ans, 01 E_pc + 8 (mod 2^WIDTH), 10 E_HI, 11 E_LO. Purely combinational.
- Reads of HI/LO while busy return the pre-operation values. The hazard unit stalls mfhi/mflo on E_md_stall.

## Timing
- Reset (reset==0, asynchronous): HI=0, LO=0, cnt=0, pend_hi/pend_lo=0, E_busy=0. E_md_stall is then driven only by the inputs.
- Reset mid-operation aborts the operation; no HI/LO update occurs afterwards.
- Start accepted at edge t0 → E_busy high from t0 through edge t0+LAT. E_busy falls and the new HI/LO become visible after edge t0+LAT.
- A back-to-back start in the cycle after E_busy falls is accepted normally.
- mthi/mtlo: value visible one cycle after the accepting edge.
- Operand changes after acceptance have no effect on the in-flight result.

## Test plan
- Reset, then mult with A=0xFFFFFFFE (−2), B=3 → E_busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. E_md_stall high in the start cycle.
- multu with A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div with A=−7, B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1) after exactly 10 busy cycles. divu with A=7, B=0 → HI/LO unchanged, busy 10 cycles.
- mthi with A=0x12345678 while busy → ignored. After busy drops, mthi with the same value → HI=0x12345678 one cycle later; s_E_GRF_Wdata=10 → E_GRF_Wdata=0x12345678.
- Assert reset at cycle 3 of a div → HI/LO=0 and E_busy=0 immediately. After reset release, no commit occurs.
- Mux check: E_ans=0xA5A5A5A5, E_pc=0x00003000 → sel 00 gives 0xA5A5A5A5, sel 01 gives 0x00003008. E_pc=0xFFFFFFFC with sel 01 → 0x00000004.
